// File: rtl/serial_collector_pkg.sv
// Shared types for the serial collector: FSM state encoding and shift-direction constants.
// The direction constants match the ALU shifter that feeds this block.
package serial_collector_pkg;

    typedef enum logic [1:0] {
        SC_IDLE    = 2'd0,
        SC_COLLECT = 2'd1,
        SC_PARITY  = 2'd2,
        SC_FULL    = 2'd3
    } sc_state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_collector_bit_counter.sv
// Bit counter for the serial collector: counts accepted data bits and flags the bit
// that completes a word, wrapping back to zero on that same edge.
module bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic wrap
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] count;

    // High on the increment that would make count reach WIDTH.
    assign wrap = inc && (count == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || wrap) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_collector.sv
// Serial-in/parallel-out collector with valid/ack output handshake and bit backpressure.
// Optional even-parity trailer bit enabled by defining SERIAL_COLLECTOR_PARITY_EN.
module serial_collector
    import serial_collector_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             dir,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ack,
    output logic             parity_err
);

    sc_state_t        state;
    sc_state_t        state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_next;
    logic             dir_q;
    logic             dir_eff;
    logic             shift_en;
    logic             wrap;
    logic             ack_take;
`ifdef SERIAL_COLLECTOR_PARITY_EN
    logic             parity_take;
    logic             parity_q;
`endif

    bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (shift_en),
        .clr   (clear),
        .wrap  (wrap)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = SC_IDLE;
        end else begin
            case (state)
                SC_IDLE:    if (shift_en) state_next = SC_COLLECT;
                SC_COLLECT: begin
                    if (shift_en && wrap) begin
`ifdef SERIAL_COLLECTOR_PARITY_EN
                        state_next = SC_PARITY;
`else
                        state_next = SC_FULL;
`endif
                    end
                end
`ifdef SERIAL_COLLECTOR_PARITY_EN
                SC_PARITY:  if (parity_take) state_next = SC_FULL;
`endif
                SC_FULL:    if (out_ack) state_next = SC_IDLE;
                default:    state_next = SC_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        bit_ready = (state != SC_FULL);
        shift_en  = bit_valid && ((state == SC_IDLE) || (state == SC_COLLECT));
        ack_take  = out_ack && (state == SC_FULL);
`ifdef SERIAL_COLLECTOR_PARITY_EN
        parity_take = bit_valid && (state == SC_PARITY);
`endif
    end

    // Direction is taken live on the first bit of a frame, then frozen in dir_q.
    assign dir_eff = (state == SC_IDLE) ? dir : dir_q;

    always_comb begin
        if (dir_eff == DIR_MSB_FIRST) begin
            shift_next = {shreg[WIDTH-2:0], bit_in};
        end else begin
            shift_next = {bit_in, shreg[WIDTH-1:1]};
        end
    end

    // NOTE: shreg and out are small control-path registers, so they take the async
    // reset; a large storage array would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            dir_q     <= DIR_MSB_FIRST;
            out       <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            shreg     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (shift_en) begin
                shreg <= shift_next;
                if (state == SC_IDLE) dir_q <= dir;
                if (wrap) begin
                    out <= shift_next;
`ifndef SERIAL_COLLECTOR_PARITY_EN
                    out_valid <= 1'b1;
`endif
                end
            end
`ifdef SERIAL_COLLECTOR_PARITY_EN
            if (parity_take) out_valid <= 1'b1;
`endif
            if (ack_take) out_valid <= 1'b0;
        end
    end

`ifdef SERIAL_COLLECTOR_PARITY_EN
    // Even parity over the held word plus the trailer bit; nonzero means mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (clear || ack_take) begin
            parity_q <= 1'b0;
        end else if (parity_take) begin
            parity_q <= ^{out, bit_in};
        end
    end

    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_collector.sv
// Directed bench for serial_collector (WIDTH=4) with an expected-word scoreboard.
// Parity cases run only when SERIAL_COLLECTOR_PARITY_EN is defined.
module tb_serial_collector;

    typedef struct {
        logic [3:0] word;
        logic       perr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       dir;
    logic [3:0] out_w;
    logic       out_valid;
    logic       out_ack;
    logic       parity_err;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    serial_collector #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .dir        (dir),
        .out        (out_w),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic d);
        @(negedge clk);
        bit_in    = b;
        dir       = d;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    // seq[3] is sent first.
    task automatic send_frame(input logic [3:0] seq, input logic d,
                              input logic [3:0] exp_word, input logic exp_perr);
        exp_t e;
        e.word = exp_word;
        e.perr = exp_perr;
        sb.push_back(e);
        for (int i = 3; i >= 0; i--) send_bit(seq[i], d);
    endtask

    task automatic expect_word(input string tag);
        exp_t e;
        int   n = 0;
        while (!out_valid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ready_low"}, 32'(bit_ready), 32'd0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_word"}, 32'(out_w), 32'(e.word));
            check({tag, "_perr"}, 32'(parity_err), 32'(e.perr));
        end
    endtask

    task automatic ack_word(input string tag);
        @(negedge clk);
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        check({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ack_ready"}, 32'(bit_ready), 32'd1);
        check({tag, "_ack_perr"}, 32'(parity_err), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        dir       = 1'b0;
        out_ack   = 1'b0;

        #12;
        check("rst_ready", 32'(bit_ready), 32'd1);
        check("rst_out", 32'(out_w), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stray ack with nothing held must be ignored.
        @(negedge clk);
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        check("idle_ack_valid", 32'(out_valid), 32'd0);
        check("idle_ack_ready", 32'(bit_ready), 32'd1);

`ifndef SERIAL_COLLECTOR_PARITY_EN
        // MSB-first 1,0,1,1
        send_frame(4'b1011, 1'b0, 4'b1011, 1'b0);
        expect_word("msb_1011");
        ack_word("msb_1011");

        // LSB-first 0,1,0,0
        send_frame(4'b0100, 1'b1, 4'b0010, 1'b0);
        expect_word("lsb_0010");
        ack_word("lsb_0010");

        // Loopback of an RSH stream of 4'b0010, then hold for backpressure.
        send_frame(4'b0100, 1'b1, 4'b0010, 1'b0);
        expect_word("loop_0010");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            @(posedge clk);
            #1;
            check("bp_out", 32'(out_w), 32'h2);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(bit_ready), 32'd0);
        end
        @(negedge clk);
        out_ack   = 1'b1;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        out_ack   = 1'b0;
        bit_valid = 1'b0;
        check("bp_ack_valid", 32'(out_valid), 32'd0);
        check("bp_ack_ready", 32'(bit_ready), 32'd1);
        check("bp_ack_out", 32'(out_w), 32'h2);

        // A clean frame proves nothing leaked in during backpressure.
        send_frame(4'b1001, 1'b0, 4'b1001, 1'b0);
        expect_word("post_bp_1001");
        ack_word("post_bp_1001");

        // Async reset mid-frame, between edges.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out_w), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ready", 32'(bit_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(4'b0110, 1'b0, 4'b0110, 1'b0);
        expect_word("after_rst_0110");
        ack_word("after_rst_0110");

        // Clear after 3 bits, with a bit offered on the same edge.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        @(negedge clk);
        clear     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        bit_valid = 1'b0;
        check("clr_out", 32'(out_w), 32'd0);
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_ready", 32'(bit_ready), 32'd1);

        // DIR toggles after the first bit; the latched MSB-first order must hold.
        sb.push_back('{word: 4'b1100, perr: 1'b0});
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        expect_word("dir_latch_1100");
        ack_word("dir_latch_1100");

        // Clear while a word is held.
        send_frame(4'b0101, 1'b0, 4'b0101, 1'b0);
        expect_word("full_0101");
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_full_valid", 32'(out_valid), 32'd0);
        check("clr_full_out", 32'(out_w), 32'd0);
        check("clr_full_ready", 32'(bit_ready), 32'd1);

        send_frame(4'b1000, 1'b1, 4'b0001, 1'b0);
        expect_word("lsb_0001");
        ack_word("lsb_0001");
`else
        // Correct even parity.
        send_frame(4'b1011, 1'b0, 4'b1011, 1'b0);
        check("par_wait_valid", 32'(out_valid), 32'd0);
        check("par_wait_ready", 32'(bit_ready), 32'd1);
        send_bit(1'b1, 1'b0);
        expect_word("par_ok");
        ack_word("par_ok");

        // Wrong parity bit.
        send_frame(4'b1011, 1'b0, 4'b1011, 1'b1);
        check("par_bad_wait_valid", 32'(out_valid), 32'd0);
        send_bit(1'b0, 1'b0);
        expect_word("par_bad");
        ack_word("par_bad");

        // LSB-first with parity.
        send_frame(4'b0100, 1'b1, 4'b0010, 1'b0);
        send_bit(1'b1, 1'b1);
        expect_word("par_lsb");
        ack_word("par_lsb");
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
